// File: rtl/cache_types_pkg.sv
// cache_types_pkg: shared types for the mp3 direct-mapped cache.
package cache_types_pkg;
    localparam int OFFSET_BITS = 4;
    localparam int IDX_BITS    = 3;
    localparam int TAG_BITS    = 16 - OFFSET_BITS - IDX_BITS;

    typedef logic [127:0]            line_t;
    typedef logic [TAG_BITS-1:0]     tag_t;
    typedef logic [IDX_BITS-1:0]     index_t;
    typedef logic [OFFSET_BITS-2:0]  word_sel_t;

    typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} cache_state_t;
endpackage

// File: rtl/cache_control.sv
// cache_control: miss-handling FSM and CPU/pmem handshake for mp3_cache.
module cache_control
    import cache_types_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic mem_read,
    input  logic mem_write,
    input  logic hit,
    input  logic valid,
    input  logic dirty,
    input  logic pmem_resp,
    output logic mem_resp,
    output logic load_word,
    output logic load_line,
    output logic pmem_read,
    output logic pmem_write
);
    cache_state_t state, state_next;
    logic req;

    assign req = mem_read | mem_write;

    always_ff @(posedge clk) begin
        state <= reset ? IDLE : state_next;
    end

    always_comb begin
        state_next = state;
        mem_resp   = state == IDLE && req && hit;
        load_word  = mem_resp && mem_write;
        pmem_write = state == WRITEBACK;
        pmem_read  = state == ALLOCATE;
        load_line  = pmem_read && pmem_resp;
        if (state == IDLE && req && !hit)
            state_next = (valid && dirty) ? WRITEBACK : ALLOCATE;
        else if (pmem_write && pmem_resp)
            state_next = ALLOCATE;
        else if (load_line)
            state_next = IDLE;
    end
endmodule

// File: rtl/mp3_cache.sv
// mp3_cache: direct-mapped write-back, write-allocate cache; 16-bit CPU port, 128-bit line pmem port.
module mp3_cache
    import cache_types_pkg::*;
#(
    parameter int NUM_SETS = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          mem_read,
    input  logic          mem_write,
    input  logic [1:0]    mem_byte_enable,
    input  logic [15:0]   mem_address,
    input  logic [15:0]   mem_wdata,
    output logic          mem_resp,
    output logic [15:0]   mem_rdata,
    output logic          pmem_read,
    output logic          pmem_write,
    output logic [15:0]   pmem_address,
    output logic [127:0]  pmem_wdata,
    input  logic          pmem_resp,
    input  logic [127:0]  pmem_rdata
);
    localparam int SET_BITS = $clog2(NUM_SETS);
    localparam int TAG_W    = 16 - OFFSET_BITS - SET_BITS;

    line_t               lines [NUM_SETS];
    logic [TAG_W-1:0]    tags  [NUM_SETS];
    logic [NUM_SETS-1:0] valid, dirty;
    logic [SET_BITS-1:0] idx;
    logic [TAG_W-1:0]    req_tag;
    word_sel_t           wsel;
    line_t               line;
    logic [15:0]         word, merged;
    logic                hit, load_word, load_line, addr_unused;

    assign addr_unused = mem_address[0];
    assign idx         = mem_address[OFFSET_BITS +: SET_BITS];
    assign req_tag     = mem_address[15 -: TAG_W];
    assign wsel        = mem_address[OFFSET_BITS-1:1];
    assign line        = lines[idx];
    assign word        = line[{wsel, 4'b0} +: 16];
    assign hit         = valid[idx] && tags[idx] == req_tag;
    assign merged      = {mem_byte_enable[1] ? mem_wdata[15:8] : word[15:8],
                          mem_byte_enable[0] ? mem_wdata[7:0]  : word[7:0]};

    // Outputs are forced to zero whenever they carry no meaning, so idle looks all-quiet.
    assign mem_rdata    = mem_resp ? word : '0;
    assign pmem_wdata   = pmem_write ? line : '0;
    assign pmem_address = pmem_write ? {tags[idx], idx, {OFFSET_BITS{1'b0}}} :
                          pmem_read  ? {req_tag,   idx, {OFFSET_BITS{1'b0}}} : '0;

    cache_control u_control (
        .clk        (clk),
        .reset      (reset),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .hit        (hit),
        .valid      (valid[idx]),
        .dirty      (dirty[idx]),
        .pmem_resp  (pmem_resp),
        .mem_resp   (mem_resp),
        .load_word  (load_word),
        .load_line  (load_line),
        .pmem_read  (pmem_read),
        .pmem_write (pmem_write)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= '0;
            dirty <= '0;
        end else if (load_line) begin
            valid[idx] <= 1'b1;
            dirty[idx] <= 1'b0;
        end else if (load_word) begin
            dirty[idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (load_line) begin
            lines[idx] <= pmem_rdata;
            tags[idx]  <= req_tag;
        end else if (load_word) begin
            lines[idx][{wsel, 4'b0} +: 16] <= merged;
        end
    end
endmodule

// File: tb/tb_mp3_cache.sv
// tb_mp3_cache: directed checks of hits, misses, writeback, reset abort and byte merging.
module tb_mp3_cache;
    logic         clk = 1'b0;
    logic         reset, mem_read, mem_write, mem_resp, pmem_read, pmem_write, pmem_resp;
    logic [1:0]   mem_byte_enable;
    logic [15:0]  mem_address, mem_wdata, mem_rdata, pmem_address;
    logic [127:0] pmem_wdata, pmem_rdata;

    localparam int           LAT = 3;
    localparam logic [127:0] L1  = 128'h7777_6666_5555_4444_3333_2222_1111_BEEF;
    localparam logic [127:0] M1  = 128'h7777_6666_5555_4444_3333_2222_1111_12EF;
    localparam logic [127:0] L9  = 128'h0909_0909_0909_0909_0909_0909_0909_CAFE;
    localparam logic [127:0] L2  = 128'h2222_2222_2222_2222_2222_2222_2222_0123;

    int           n_checks = 0, n_errors = 0, both_cnt = 0;
    int           cyc, nrd, nwr, presp_cyc, rd_cyc, wr_cyc;
    logic         got_resp;
    logic [15:0]  rdata, rd_addr, wr_addr;
    logic [127:0] wr_data;
    logic [127:0] pmem [4096];

    always #5 clk = ~clk;

    mp3_cache dut (
        .clk             (clk),
        .reset           (reset),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_byte_enable (mem_byte_enable),
        .mem_address     (mem_address),
        .mem_wdata       (mem_wdata),
        .mem_resp        (mem_resp),
        .mem_rdata       (mem_rdata),
        .pmem_read       (pmem_read),
        .pmem_write      (pmem_write),
        .pmem_address    (pmem_address),
        .pmem_wdata      (pmem_wdata),
        .pmem_resp       (pmem_resp),
        .pmem_rdata      (pmem_rdata)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One CPU request held until mem_resp, with a fixed-latency pmem responder alongside.
    task automatic access(input logic rd, input logic wr, input logic [1:0] be,
                          input logic [15:0] addr, input logic [15:0] wd);
        int pcnt = 0;
        nrd = 0; nwr = 0; got_resp = 0; presp_cyc = -1; rd_cyc = -1; wr_cyc = -1; cyc = -1;
        @(negedge clk);
        mem_read = rd; mem_write = wr; mem_byte_enable = be; mem_address = addr; mem_wdata = wd;
        for (int c = 0; c < 60 && !got_resp; c++) begin
            #1;
            if (pmem_read && pmem_write) both_cnt++;
            if (mem_resp) begin
                got_resp = 1; cyc = c; rdata = mem_rdata;
            end else if (pmem_read || pmem_write) begin
                if (pcnt == LAT) begin
                    pcnt = 0; pmem_resp = 1; presp_cyc = c;
                    if (pmem_write) begin
                        nwr++; wr_cyc = c; wr_addr = pmem_address; wr_data = pmem_wdata;
                        pmem[pmem_address[15:4]] = pmem_wdata;
                    end else begin
                        nrd++; rd_cyc = c; rd_addr = pmem_address;
                        pmem_rdata = pmem[pmem_address[15:4]];
                    end
                end else pcnt++;
            end
            @(negedge clk);
            pmem_resp = 0;
        end
        mem_read = 0; mem_write = 0;
        check("resp_seen", {127'b0, got_resp}, 128'd1);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) pmem[i] = '0;
        pmem[1] = L1; pmem[9] = L9; pmem[2] = L2;
        reset = 1; mem_read = 0; mem_write = 0; mem_byte_enable = 0;
        mem_address = 0; mem_wdata = 0; pmem_resp = 0; pmem_rdata = 0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_resp", mem_resp, 0);
        check("rst_pread", pmem_read, 0);
        check("rst_pwrite", pmem_write, 0);
        check("rst_paddr", pmem_address, 0);
        check("rst_pwdata", pmem_wdata, 0);
        reset = 0;
        @(negedge clk); #1;
        check("idle_outs", {mem_resp, mem_rdata, pmem_read, pmem_write, pmem_address}, 0);

        access(1, 0, 2'b11, 16'h0010, 0);
        check("t1_nrd", nrd, 1);
        check("t1_nwr", nwr, 0);
        check("t1_paddr", rd_addr, 16'h0010);
        check("t1_lat", cyc, presp_cyc + 1);
        check("t1_rdata", rdata, 16'hBEEF);

        access(1, 0, 2'b11, 16'h0012, 0);
        check("t2_cyc", cyc, 0);
        check("t2_pmem", nrd + nwr, 0);
        check("t2_rdata", rdata, 16'h1111);

        access(0, 1, 2'b10, 16'h0010, 16'h1234);
        check("t3_cyc", cyc, 0);
        access(1, 0, 2'b11, 16'h0010, 0);
        check("t3_rdata", rdata, 16'h12EF);

        access(1, 0, 2'b11, 16'h0090, 0);
        check("t4_nwr", nwr, 1);
        check("t4_waddr", wr_addr, 16'h0010);
        check("t4_wdata", wr_data, M1);
        check("t4_nrd", nrd, 1);
        check("t4_raddr", rd_addr, 16'h0090);
        check("t4_order", wr_cyc < rd_cyc, 1);
        check("t4_rdata", rdata, 16'hCAFE);

        @(negedge clk);
        mem_read = 1; mem_address = 16'h0030; mem_byte_enable = 2'b11;
        #1 check("t5_idle_miss", pmem_read, 0);
        @(negedge clk); #1;
        check("t5_alloc", pmem_read, 1);
        check("t5_alloc_addr", pmem_address, 16'h0030);
        reset = 1;
        @(negedge clk); #1;
        check("t5_abort", pmem_read, 0);
        check("t5_abort_addr", pmem_address, 0);
        reset = 0; mem_read = 0; pmem_resp = 1; pmem_rdata = '1;
        @(negedge clk);
        pmem_resp = 0;
        #1 check("t5_stale", {mem_resp, pmem_read, pmem_write}, 0);
        access(1, 0, 2'b11, 16'h0010, 0);
        check("t5_miss", nrd, 1);
        check("t5_rdata", rdata, 16'h12EF);

        access(1, 1, 2'b01, 16'h0010, 16'hAB55);
        check("t6_cyc", cyc, 0);
        check("t6_pmem", nrd + nwr, 0);
        access(1, 0, 2'b11, 16'h0010, 0);
        check("t6_rdata", rdata, 16'h1255);
        access(1, 0, 2'b11, 16'h0090, 0);
        check("t6_nwr", nwr, 1);
        check("t6_waddr", wr_addr, 16'h0010);
        check("t6_wword", wr_data[15:0], 16'h1255);
        check("t6_rdata", rdata, 16'hCAFE);

        access(1, 0, 2'b11, 16'h0020, 0);
        check("t7_fill", rdata, 16'h0123);
        access(0, 1, 2'b00, 16'h0020, 16'hFFFF);
        check("t7_cyc", cyc, 0);
        access(1, 0, 2'b11, 16'h0020, 0);
        check("t7_rdata", rdata, 16'h0123);
        access(1, 0, 2'b11, 16'h00A0, 0);
        check("t7_nwr", nwr, 1);
        check("t7_waddr", wr_addr, 16'h0020);
        check("t7_wdata", wr_data, L2);

        check("pmem_excl", both_cnt, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
